// File: rtl/wash_program_timer.sv
// ============================================================================
// Module   : wash_program_timer
// Purpose  : Power-on/finish countdowns and wash/rinse/spin phase sequencing
//            for the washing-machine controller. Optional: WM_DOUBLE_RINSE_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wash_program_timer #(
    parameter int INIT_SEC   = 3,
    parameter int FINISH_SEC = 4,
    parameter int WASH_SEC   = 6,
    parameter int RINSE_SEC  = 4,
    parameter int SPIN_SEC   = 3
) (
    input  logic       cp,
    input  logic       reset,
    input  logic       tick,
    input  logic [2:0] state,
    input  logic [1:0] mode,
    output logic [2:0] initTime,
    output logic [2:0] finishTime,
    output logic       hadFinish,
    output logic [1:0] phase,
    output logic [9:0] remain
);

    localparam logic [2:0] ST_SHUTDOWN = 3'd0;
    localparam logic [2:0] ST_BEGIN    = 3'd1;
    localparam logic [2:0] ST_SET      = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd6;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_WASH  = 2'd1;
    localparam logic [1:0] PH_RINSE = 2'd2;
    localparam logic [1:0] PH_SPIN  = 2'd3;

    localparam logic [1:0] PROG_FULL = 2'd0;
    localparam logic [1:0] PROG_SPIN = 2'd2;

    localparam logic [2:0] INIT_VAL   = 3'(INIT_SEC);
    localparam logic [2:0] FINISH_VAL = 3'(FINISH_SEC);
    localparam logic [7:0] W_LEN      = 8'(WASH_SEC);
    localparam logic [7:0] R_LEN      = 8'(RINSE_SEC);
    localparam logic [7:0] S_LEN      = 8'(SPIN_SEC);

    // Program steps: 0 wash, 1 rinse, 2 second rinse, 3 spin; 4 means none.
    localparam logic [2:0] STEP_NONE = 3'd4;
`ifdef WM_DOUBLE_RINSE_EN
    localparam bit DOUBLE_RINSE = 1'b1;
`else
    localparam bit DOUBLE_RINSE = 1'b0;
`endif

    logic [2:0] initTime_q, initTime_d;
    logic [2:0] finishTime_q, finishTime_d;
    logic       hadFinish_q, hadFinish_d;
    logic [1:0] phase_q, phase_d;
    logic [9:0] remain_q, remain_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] prog_q, prog_d;
    logic       pass_d;
    logic       pass_w;

    function automatic logic [7:0] f_step_len(input logic [2:0] s);
        case (s)
            3'd0:         f_step_len = W_LEN;
            3'd1, 3'd2:   f_step_len = R_LEN;
            3'd3:         f_step_len = S_LEN;
            default:      f_step_len = 8'd0;
        endcase
    endfunction

    function automatic logic f_step_used(input logic [1:0] prog, input logic [2:0] s);
        case (s)
            3'd0:    f_step_used = (prog == PROG_FULL);
            3'd1:    f_step_used = (prog != PROG_SPIN);
            3'd2:    f_step_used = (prog != PROG_SPIN) && DOUBLE_RINSE;
            3'd3:    f_step_used = 1'b1;
            default: f_step_used = 1'b0;
        endcase
    endfunction

    // First included, nonzero-length step at or after 'from'.
    function automatic logic [2:0] f_next_step(input logic [1:0] prog, input logic [2:0] from);
        logic [2:0] res;
        res = STEP_NONE;
        for (int s = 3; s >= 0; s--) begin
            if (s >= int'(from) && f_step_used(prog, 3'(s)) && f_step_len(3'(s)) != 8'd0)
                res = 3'(s);
        end
        return res;
    endfunction

    function automatic logic [9:0] f_total(input logic [1:0] prog);
        logic [9:0] sum;
        sum = 10'd0;
        for (int s = 0; s < 4; s++) begin
            if (f_step_used(prog, 3'(s)))
                sum = sum + {2'b00, f_step_len(3'(s))};
        end
        return sum;
    endfunction

    function automatic logic [1:0] f_step_phase(input logic [2:0] s);
        case (s)
            3'd0:       f_step_phase = PH_WASH;
            3'd1, 3'd2: f_step_phase = PH_RINSE;
            3'd3:       f_step_phase = PH_SPIN;
            default:    f_step_phase = PH_IDLE;
        endcase
    endfunction

`ifdef WM_DOUBLE_RINSE_EN
    logic pass_q;
    assign pass_w = pass_q;
    always_ff @(posedge cp) begin
        if (reset) pass_q <= 1'b0;
        else       pass_q <= pass_d;
    end
`else
    assign pass_w = 1'b0;
`endif

    always_ff @(posedge cp) begin
        if (reset) begin
            initTime_q   <= INIT_VAL;
            finishTime_q <= FINISH_VAL;
            hadFinish_q  <= 1'b0;
            phase_q      <= PH_IDLE;
            remain_q     <= 10'd0;
            cnt_q        <= 8'd0;
            prog_q       <= PROG_FULL;
        end else begin
            initTime_q   <= initTime_d;
            finishTime_q <= finishTime_d;
            hadFinish_q  <= hadFinish_d;
            phase_q      <= phase_d;
            remain_q     <= remain_d;
            cnt_q        <= cnt_d;
            prog_q       <= prog_d;
        end
    end

    logic [2:0] cur_step;
    logic [2:0] step_sel;
    logic [7:0] cnt_cur;
    logic       active;

    always_comb begin
        initTime_d   = initTime_q;
        finishTime_d = (state == ST_FINISH) ? finishTime_q : FINISH_VAL;
        hadFinish_d  = hadFinish_q;
        phase_d      = phase_q;
        remain_d     = remain_q;
        cnt_d        = cnt_q;
        prog_d       = prog_q;
        pass_d       = pass_w;
        step_sel     = STEP_NONE;
        cnt_cur      = cnt_q;
        active       = 1'b0;
        case (phase_q)
            PH_WASH:  cur_step = 3'd0;
            PH_RINSE: cur_step = pass_w ? 3'd2 : 3'd1;
            PH_SPIN:  cur_step = 3'd3;
            default:  cur_step = 3'd0;
        endcase

        case (state)
            ST_SHUTDOWN: begin
                initTime_d  = INIT_VAL;
                hadFinish_d = 1'b0;
                phase_d     = PH_IDLE;
                remain_d    = 10'd0;
                pass_d      = 1'b0;
            end
            ST_BEGIN: begin
                if (tick && initTime_q != 3'd0)
                    initTime_d = initTime_q - 3'd1;
            end
            ST_SET: begin
                prog_d      = (mode == 2'd3) ? PROG_FULL : mode;
                remain_d    = f_total(prog_d);
                phase_d     = PH_IDLE;
                hadFinish_d = 1'b0;
                pass_d      = 1'b0;
            end
            ST_RUN: begin
                // Select the step that owns this cycle; a load and a tick may share an edge.
                if (phase_q == PH_IDLE) begin
                    if (!hadFinish_q) begin
                        step_sel = f_next_step(prog_q, 3'd0);
                        active   = (step_sel != STEP_NONE);
                        cnt_cur  = f_step_len(step_sel);
                        if (!active)
                            hadFinish_d = 1'b1;
                    end
                end else if (cnt_q == 8'd0) begin
                    step_sel = f_next_step(prog_q, cur_step + 3'd1);
                    active   = (step_sel != STEP_NONE);
                    cnt_cur  = f_step_len(step_sel);
                    if (!active) begin
                        phase_d     = PH_IDLE;
                        hadFinish_d = 1'b1;
                    end
                end else begin
                    step_sel = cur_step;
                    active   = 1'b1;
                end

                if (active) begin
                    phase_d = f_step_phase(step_sel);
                    pass_d  = (step_sel == 3'd2);
                    cnt_d   = cnt_cur;
                    if (tick) begin
                        cnt_d = cnt_cur - 8'd1;
                        if (remain_q != 10'd0)
                            remain_d = remain_q - 10'd1;
                        if (cnt_cur == 8'd1 && f_next_step(prog_q, step_sel + 3'd1) == STEP_NONE) begin
                            phase_d     = PH_IDLE;
                            pass_d      = 1'b0;
                            hadFinish_d = 1'b1;
                        end
                    end
                end
            end
            ST_FINISH: begin
                if (tick && finishTime_q != 3'd0)
                    finishTime_d = finishTime_q - 3'd1;
            end
            default: ; // pause, error and code 7 hold everything
        endcase
    end

    always_comb begin
        initTime   = initTime_q;
        finishTime = finishTime_q;
        hadFinish  = hadFinish_q;
        phase      = phase_q;
        remain     = remain_q;
    end

endmodule

`default_nettype wire

// File: doc/wash_program_timer.md
# wash_program_timer

- Companion to the washing-machine state controller.
- Consumes the controller's 3-bit `state` code and a one-cycle seconds `tick`.
- Produces the status the controller branches on:
  - `initTime`: power-on countdown.
  - `finishTime`: end-of-cycle countdown.
  - `hadFinish`: wash program completion.
- Also sequences the wash/rinse/spin phases and reports phase and remaining seconds for display.

## Interface

Parameters:
- `INIT_SEC`, 3: power-on countdown length in ticks, 1..7.
- `FINISH_SEC`, 4: finish countdown length in ticks, 1..7.
- `WASH_SEC`, 6: wash phase length in ticks, 0..255.
- `RINSE_SEC`, 4: rinse phase length in ticks, 0..255.
- `SPIN_SEC`, 3: spin phase length in ticks, 0..255.

Ports:
- `cp`, input, 1: clock, rising edge.
- `reset`, input, 1: synchronous reset, active-high.
- `tick`, input, 1: one-cycle pulse per second.
- `state`, input, 3: controller state code. 0 shutDown, 1 begin, 2 set, 3 run, 4 error, 5 pause, 6 finish; 7 is treated as error.
- `mode`, input, 2: program select, sampled in set. 0 full, 1 rinse+spin, 2 spin-only, 3 is treated as 0.
- `initTime`, output, 3: power-on countdown.
- `finishTime`, output, 3: finish countdown.
- `hadFinish`, output, 1: program complete.
- `phase`, output, 2: 0 IDLE, 1 WASH, 2 RINSE, 3 SPIN.
- `remain`, output, 10: total ticks left in the program.

## Operation

Reset values:
- `initTime`=INIT_SEC, `finishTime`=FINISH_SEC.
- `hadFinish`=0, `phase`=IDLE, `remain`=0, phase counter `cnt`=0, latched program = full.

Behaviour per `state`:
- **shutDown:**
  - Reload `initTime`=INIT_SEC.
  - Clear `hadFinish`.
  - Set `phase`=IDLE, `remain`=0.
- **begin:** on `tick`, decrement `initTime`, saturating at 0.
- **set:**
  - Latch `mode` every cycle.
  - Preload `remain` with the program total.
  - Set `phase`=IDLE and clear `hadFinish`.
- **run:**
  - If `phase`=IDLE, load the first phase of the latched program that has nonzero length.
  - Set `cnt` to that phase's length; this load needs no tick.
  - If all lengths are 0, set `hadFinish`=1 instead.
  - On each `tick`:
    - Decrement `cnt` and `remain`.
    - When `cnt` goes 1→0, the next cycle loads the next nonzero phase.
    - When no phase remains, set `phase`=IDLE and `hadFinish`=1.
  - `hadFinish` is sticky until set or shutDown.
- **pause, error:** hold every register; ignore ticks.
- **finish:** on `tick`, decrement `finishTime`, saturating at 0.
- **All states except finish:** `finishTime`=FINISH_SEC.

Program sequences:
- full: WASH→RINSE→SPIN.
- rinse+spin: RINSE→SPIN.
- spin-only: SPIN.
- Zero-length phases are skipped.
- `remain` = sum of the included phase lengths (with double rinse, RINSE_SEC counts twice).

## Timing

- All outputs are registered and update on the `cp` edge where the condition (`state`, `tick`) is sampled; latency is one cycle.
- `state` is taken as its pre-edge value. A tick coincident with a state change applies to the old state.
- `hadFinish` rises on the same edge on which `remain` reaches 0.
- Phase advance costs one cycle with no tick consumed. A `tick` arriving in that cycle is applied to the newly loaded `cnt`.
- `mode` changes outside set have no effect.
- Reset takes priority over everything, including a coincident tick.
- Reset mid-run discards all progress.
- Ticks in error or pause are lost; they are not queued.

## Configuration

`WM_DOUBLE_RINSE_EN`:
- **Defined:**
  - Full and rinse+spin programs run RINSE twice back-to-back.
  - `phase` stays 2 across both passes; `cnt` reloads RINSE_SEC between passes.
  - An internal pass bit is cleared on set and shutDown.
  - `remain` includes both passes.
- **Undefined:** single rinse; no pass bit.

## Test plan

- **Reset/power-on.** Reset, then state=1 with 3 ticks → `initTime` 3,2,1,0, then holds 0 on a 4th tick. Then state=0 → `initTime` returns to 3.
- **Full program, double rinse undefined.**
  - Setup: mode=0 in set, then run with 13 ticks.
  - After set: `remain`=13.
  - Phase sequence: 1 for 6 ticks, 2 for 4, 3 for 3.
  - `hadFinish`=1 on the edge where `remain`=0.
  - `phase`=IDLE afterwards.
- **Pause.** Run 2 ticks, then pause with 5 ticks → `remain`=11 and `cnt`=4 unchanged. Resume run → WASH continues for 4 more ticks.
- **Spin-only with WASH_SEC=0 override, mode=2.** → `remain`=3, `phase` goes straight to 3, `hadFinish` after 3 ticks. Separately, mode=3 behaves identically to mode=0.
- **Finish countdown.** state=6 with 5 ticks → `finishTime` 4,3,2,1,0, then holds 0. Leaving finish → `finishTime` returns to 4.
- **Double rinse defined, mode=1.** → `remain`=11; `phase`=2 for 8 ticks, then 3 for 3 ticks; `hadFinish` on the 11th tick.
